// File: rtl/mips_mem_pkg.sv
// Shared types for the data-memory arbiter: FSM state encoding, grant-source
// encoding and the width of the DMA starvation counter.
package mips_mem_pkg;

    // Arbiter FSM states. The two wait states mark the cycle in which a
    // synchronous memory read issued in the previous cycle returns its data.
    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        CPU_RD_WAIT = 2'd1,
        DMA_RD_WAIT = 2'd2
    } state_t;

    // Which requester owns the memory port in the current cycle.
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_CPU  = 2'd1,
        GNT_DMA  = 2'd2
    } gnt_src_t;

    // Width of the starvation counter; limits up to 15 are representable.
    localparam int STARVE_CNT_W = 4;

endpackage : mips_mem_pkg

// File: rtl/arb_starve_counter.sv
// Saturating count of consecutive cycles the DMA requester has been refused,
// plus the compare that forces the next free port to the DMA requester.
module arb_starve_counter
    import mips_mem_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    dma_req,
    input  logic                    dma_gnt,
    output logic [STARVE_CNT_W-1:0] starve_cnt,
    output logic                    force_dma
);

    localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

    // DMA takes priority once it has been refused LIMIT cycles in a row.
    assign force_dma = (starve_cnt == LIMIT);

    // Count refused DMA cycles; clear on a grant or when DMA stops asking.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            starve_cnt <= '0;
        end else if (!dma_req || dma_gnt) begin
            starve_cnt <= '0;
        end else if (starve_cnt != LIMIT) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule : arb_starve_counter

// File: rtl/data_mem_arbiter.sv
// Arbitrates the single-port data memory between the pipeline MEM stage and a
// DMA/loader. The CPU has fixed priority, except that a DMA requester refused
// for STARVE_LIMIT consecutive cycles wins the next free port. Memory strobes
// and read-data returns are combinational from state and the live requests.
module data_mem_arbiter
    import mips_mem_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int ADDR_W       = 32
) (
    input  logic              Clk,
    input  logic              Reset,

    // Pipeline MEM stage
    input  logic              CPU_Read,
    input  logic              CPU_Write,
    input  logic [ADDR_W-1:0] CPU_Addr,
    input  logic [31:0]       CPU_Write_Data,
    output logic [31:0]       CPU_Read_Data,
    output logic              CPU_Stall,

    // DMA / loader
    input  logic              DMA_Req,
    input  logic              DMA_We,
    input  logic [ADDR_W-1:0] DMA_Addr,
    input  logic [31:0]       DMA_Write_Data,
    output logic              DMA_Gnt,
    output logic              DMA_Rvalid,
    output logic [31:0]       DMA_Read_Data,

    // Data memory
    output logic [ADDR_W-1:0] Mem_Addr,
    output logic [31:0]       Mem_Write_Data,
    output logic              Mem_Read,
    output logic              Mem_Write,
    input  logic [31:0]       Mem_Read_Data
);

    state_t                  state;
    state_t                  next_state;
    gnt_src_t                gnt;
    logic                    cpu_req;
    logic                    cpu_eligible;
    logic                    force_dma;
    logic [STARVE_CNT_W-1:0] starve_cnt;

    assign cpu_req = CPU_Read | CPU_Write;

    // In CPU_RD_WAIT the CPU strobe is still held for the read now completing,
    // so it must not be re-issued; the port is free for DMA only.
    assign cpu_eligible = cpu_req && (state != CPU_RD_WAIT);

    arb_starve_counter #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve (
        .Clk        (Clk),
        .Reset      (Reset),
        .dma_req    (DMA_Req),
        .dma_gnt    (DMA_Gnt),
        .starve_cnt (starve_cnt),
        .force_dma  (force_dma)
    );

    // Pick the port owner: starved DMA, then CPU, then any DMA request.
    always_comb begin
        gnt = GNT_NONE;
        if (!Reset) begin
            if (DMA_Req && force_dma) begin
                gnt = GNT_DMA;
            end else if (cpu_eligible) begin
                gnt = GNT_CPU;
            end else if (DMA_Req) begin
                gnt = GNT_DMA;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Drive the memory port from the winner and choose the next state.
    // NOTE: every output of this block is given a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        next_state     = IDLE;
        Mem_Addr       = '0;
        Mem_Write_Data = '0;
        Mem_Read       = 1'b0;
        Mem_Write      = 1'b0;
        DMA_Gnt        = 1'b0;

        unique case (gnt)
            GNT_CPU: begin
                Mem_Addr       = CPU_Addr;
                Mem_Write_Data = CPU_Write_Data;
                Mem_Read       = CPU_Read;
                Mem_Write      = CPU_Write;
                if (CPU_Read) begin
                    next_state = CPU_RD_WAIT;
                end
            end
            GNT_DMA: begin
                Mem_Addr       = DMA_Addr;
                Mem_Write_Data = DMA_Write_Data;
                Mem_Read       = !DMA_We;
                Mem_Write      = DMA_We;
                DMA_Gnt        = 1'b1;
                if (!DMA_We) begin
                    next_state = DMA_RD_WAIT;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Pipeline stall: released while a CPU read completes or a store is
    // accepted; held for an issued read or a request that lost arbitration.
    always_comb begin
        CPU_Stall = 1'b0;
        if (!Reset && state != CPU_RD_WAIT && cpu_req) begin
            if (gnt == GNT_CPU) begin
                CPU_Stall = CPU_Read;
            end else begin
                CPU_Stall = 1'b1;
            end
        end
    end

    // Route returning read data to whichever requester owns the wait state.
    // Reset forces state to IDLE at once, which also drops any pending return.
    always_comb begin
        CPU_Read_Data = '0;
        DMA_Read_Data = '0;
        DMA_Rvalid    = 1'b0;
        if (state == CPU_RD_WAIT) begin
            CPU_Read_Data = Mem_Read_Data;
        end
        if (state == DMA_RD_WAIT) begin
            DMA_Rvalid    = 1'b1;
            DMA_Read_Data = Mem_Read_Data;
        end
    end

endmodule : data_mem_arbiter

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Shares the single-port data memory between the pipeline MEM stage (CPU) and a DMA/loader requester. It sits between the MEM stage and the data memory, and drives the memory's address, data and read/write strobes. It stalls the pipeline while a CPU access is pending or has lost arbitration. The CPU has fixed priority; a starvation counter forces a DMA grant after a bounded wait.

## Interface
- STARVE_LIMIT, 4: consecutive cycles DMA may be refused before it takes priority (1..15)
- ADDR_W, 32: address width
- Clk  in  1  clock, all state on posedge
- Reset  in  1  asynchronous, active-high
- CPU_Read / CPU_Write  in  1  MEM-stage strobes, held while CPU_Stall=1; never both high
- CPU_Addr  in  ADDR_W  word address
- CPU_Write_Data  in  32  store data
- CPU_Read_Data  out  32  load data, valid in the cycle CPU_Stall falls after a read
- CPU_Stall  out  1  freeze pipeline
- DMA_Req, DMA_We  in  1  request; write when DMA_We=1; held until DMA_Gnt
- DMA_Addr  in  ADDR_W; DMA_Write_Data  in  32
- DMA_Gnt  out  1  one-cycle pulse: request issued to memory this cycle
- DMA_Rvalid  out  1; DMA_Read_Data  out  32  read return
- Mem_Addr  out  ADDR_W; Mem_Write_Data  out  32; Mem_Read, Mem_Write  out  1
- Mem_Read_Data  in  32  synchronous read, valid one cycle after Mem_Read

## Operation
- FSM states: IDLE, CPU_RD_WAIT, DMA_RD_WAIT.
- Port free: in IDLE and DMA_RD_WAIT for both requesters; in CPU_RD_WAIT for DMA only, because the CPU's held read is completing.
- Arbitration, combinational, on a free port: DMA wins if starve_cnt == STARVE_LIMIT; otherwise the CPU wins when it has an eligible request; otherwise DMA.
- The winner's address, data and strobe drive Mem_*; all other cycles Mem_Read = Mem_Write = 0, Mem_Addr/Mem_Write_Data = 0.
- CPU write granted: CPU_Stall=0 that cycle.
- CPU read granted: CPU_Stall=1, next state CPU_RD_WAIT.
- CPU_RD_WAIT: CPU_Read_Data = Mem_Read_Data, CPU_Stall=0. The CPU request is not re-issued.
- CPU request not granted: CPU_Stall=1.
- DMA granted: DMA_Gnt=1. For a read, next state is DMA_RD_WAIT, which asserts DMA_Rvalid with DMA_Read_Data = Mem_Read_Data.
- Next state when leaving IDLE/RD_WAIT is set by the current grant: a CPU read → CPU_RD_WAIT, a DMA read → DMA_RD_WAIT, else IDLE.
- starve_cnt (4-bit): +1 each cycle DMA_Req=1 and DMA_Gnt=0, saturating at STARVE_LIMIT. Cleared on DMA_Gnt or DMA_Req=0.
- No request anywhere: IDLE, CPU_Stall=0.

## Timing
- Reset (async assert): state IDLE, starve_cnt 0. All outputs 0 while Reset=1: CPU_Stall, DMA_Gnt, DMA_Rvalid, Mem_*, and both read-data outputs.
- Reset mid-read drops the outstanding read: no DMA_Rvalid, and no stale CPU_Read_Data.
- Uncontended CPU load: 2 cycles (1 stall). CPU store: 0 stall.
- DMA read: DMA_Gnt in cycle N, DMA_Rvalid in N+1. DMA write: done in the DMA_Gnt cycle.
- Back-to-back: a DMA read in CPU_RD_WAIT returns in the next cycle. A CPU op issued in DMA_RD_WAIT overlaps the DMA return.
- Forced DMA grant while the CPU requests: CPU_Stall=1 that cycle, and starve_cnt clears.
- Mem_* outputs are combinational from state and requests. Read-data outputs pass through Mem_Read_Data combinationally, gated by state.

## Structure
- Package mips_mem_pkg: state enum (IDLE=2'd0, CPU_RD_WAIT=2'd1, DMA_RD_WAIT=2'd2) and a grant-source encoding (GNT_NONE, GNT_CPU, GNT_DMA).
- One natural sub-module, arb_starve_counter: the saturating counter plus its force-priority compare, parameterised by STARVE_LIMIT.

## Test plan
- Reset, then CPU_Read addr 8 with memory[8]=32'hDEADBEEF → CPU_Stall=1 for 1 cycle, then CPU_Read_Data=32'hDEADBEEF with CPU_Stall=0.
- CPU_Write addr 3 data 32'h12345678 → Mem_Write=1 the same cycle, no stall; a later DMA read of addr 3 returns 32'h12345678 with DMA_Rvalid one cycle after DMA_Gnt.
- CPU issues a store every cycle while DMA_Req is held (STARVE_LIMIT=4) → DMA_Gnt exactly in cycle 5, CPU_Stall=1 that cycle only.
- CPU read and DMA read in the same cycle → CPU issued first; DMA_Gnt in CPU_RD_WAIT; CPU_Read_Data then DMA_Rvalid in consecutive cycles.
- DMA read granted, then Reset asserted in DMA_RD_WAIT → DMA_Rvalid never asserts, all outputs 0, state IDLE after release.
- No requests for 10 cycles → CPU_Stall=0, Mem_Read=Mem_Write=0, starve_cnt=0 throughout.
